// File: rtl/code_lock_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// code_lock_ctrl
//
// Purpose:
//   Lock controller behind the 4-digit BCD switch-entry block. On a CONFIRM
//   pulse the entered digits are latched and checked one cycle later against
//   the stored user code and the fixed admin key. The controller opens the
//   lock, reports failures, enters code-change (ADMIN) mode and raises a timed
//   alarm after MAX_TRIES consecutive failures.
//
// Ports:
//   CLK           in   system clock
//   RESET_N       in   asynchronous active-low reset
//   SEQUENCE      in   [15:0] entered digits, digit 0 in [3:0], unused = 4'hF
//   SEQUENCE_BIT  in   [2:0]  number of digits entered (0..4)
//   CONFIRM       in   one-cycle confirm pulse
//   CLEAR         in   one-cycle abort / relock pulse
//   UNLOCK        out  lock open
//   ALARM         out  lockout alarm active
//   FAIL          out  one-cycle pulse on wrong / invalid code
//   INPUT_ERR     out  one-cycle pulse on a malformed CONFIRM
//   CODE_UPDATED  out  one-cycle pulse when a new user code is stored
//   SEQ_CLEAR     out  one-cycle pulse telling the entry block to discard
//   ERR_CNT       out  [3:0] consecutive failure count
//   STATE         out  [2:0] LOCKED=0 CHECK=1 OPEN=2 ADMIN=3 ALARM=4
//
// Configuration macro:
//   CODE_LOCK_RETAIN_CODE_EN - when defined, the user-code register is not
//   touched by RESET_N (only a register initialiser loads DEFAULT_CODE), so a
//   code changed in ADMIN mode survives a reset.
// -----------------------------------------------------------------------------
module code_lock_ctrl #(
    parameter logic [15:0] DEFAULT_CODE = 16'h1234,
    parameter logic [15:0] ADMIN_KEY    = 16'h9999,
    parameter int          MAX_TRIES    = 3,
    parameter int          UNLOCK_TICKS = 100,
    parameter int          ALARM_TICKS  = 200
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [15:0] SEQUENCE,
    input  logic [2:0]  SEQUENCE_BIT,
    input  logic        CONFIRM,
    input  logic        CLEAR,
    output logic        UNLOCK,
    output logic        ALARM,
    output logic        FAIL,
    output logic        INPUT_ERR,
    output logic        CODE_UPDATED,
    output logic        SEQ_CLEAR,
    output logic [3:0]  ERR_CNT,
    output logic [2:0]  STATE
);

    typedef enum logic [2:0] {
        ST_LOCKED = 3'd0,
        ST_CHECK  = 3'd1,
        ST_OPEN   = 3'd2,
        ST_ADMIN  = 3'd3,
        ST_ALARM  = 3'd4
    } state_t;

    // The code parameters are written in keypad order (first typed digit
    // leftmost, so "1234" reads as typed). The entry block packs the first
    // typed digit into [3:0], so the parameters are nibble-reversed once here
    // to share the SEQUENCE packing; e.g. DEFAULT_CODE 16'h1234 is matched by
    // SEQUENCE 16'h4321.
    localparam logic [15:0] RESET_CODE = {DEFAULT_CODE[3:0], DEFAULT_CODE[7:4],
                                          DEFAULT_CODE[11:8], DEFAULT_CODE[15:12]};
    localparam logic [15:0] ADMIN_CODE = {ADMIN_KEY[3:0], ADMIN_KEY[7:4],
                                          ADMIN_KEY[11:8], ADMIN_KEY[15:12]};
    localparam logic [3:0]  MAX_CNT    = 4'(MAX_TRIES);
    localparam logic [15:0] UNLOCK_LD  = 16'(UNLOCK_TICKS);
    localparam logic [15:0] ALARM_LD   = 16'(ALARM_TICKS);

    function automatic logic bcd_ok(input logic [15:0] v);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) &&
               (v[11:8] <= 4'd9) && (v[15:12] <= 4'd9);
    endfunction

    state_t      r_state;
    logic [15:0] r_timer;
    logic [15:0] r_cand;
    logic [3:0]  w_err_next;
    logic        w_entry_ok;
    logic        w_cand_ok;
    logic        w_code_we;

    assign w_entry_ok = (SEQUENCE_BIT == 3'd4) && bcd_ok(SEQUENCE);
    assign w_cand_ok  = bcd_ok(r_cand);
    // Saturating increment of the failure count.
    assign w_err_next = (ERR_CNT >= MAX_CNT) ? MAX_CNT : ERR_CNT + 4'd1;
    // CLEAR has priority over CONFIRM in ADMIN, so it also blocks the write.
    assign w_code_we  = (r_state == ST_ADMIN) && !CLEAR && CONFIRM && w_entry_ok;
    assign STATE      = r_state;

`ifdef CODE_LOCK_RETAIN_CODE_EN
    logic [15:0] r_code = RESET_CODE;

    always_ff @(posedge CLK) begin
        if (w_code_we) r_code <= SEQUENCE;
    end
`else
    logic [15:0] r_code;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)       r_code <= RESET_CODE;
        else if (w_code_we) r_code <= SEQUENCE;
    end
`endif

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state      <= ST_LOCKED;
            r_timer      <= 16'd0;
            r_cand       <= 16'hFFFF;
            UNLOCK       <= 1'b0;
            ALARM        <= 1'b0;
            FAIL         <= 1'b0;
            INPUT_ERR    <= 1'b0;
            CODE_UPDATED <= 1'b0;
            SEQ_CLEAR    <= 1'b0;
            ERR_CNT      <= 4'd0;
        end else begin
            // Pulse outputs default low every cycle.
            FAIL         <= 1'b0;
            INPUT_ERR    <= 1'b0;
            CODE_UPDATED <= 1'b0;
            SEQ_CLEAR    <= 1'b0;

            case (r_state)
                ST_LOCKED: begin
                    if (CONFIRM) begin
                        if (SEQUENCE_BIT != 3'd4) begin
                            INPUT_ERR <= 1'b1;
                        end else begin
                            r_cand    <= SEQUENCE;
                            SEQ_CLEAR <= 1'b1;
                            r_state   <= ST_CHECK;
                        end
                    end
                end

                ST_CHECK: begin
                    // User code first: a user code equal to the admin key opens.
                    if (w_cand_ok && r_cand == r_code) begin
                        ERR_CNT <= 4'd0;
                        r_timer <= UNLOCK_LD;
                        UNLOCK  <= 1'b1;
                        r_state <= ST_OPEN;
                    end else if (w_cand_ok && r_cand == ADMIN_CODE) begin
                        ERR_CNT <= 4'd0;
                        r_state <= ST_ADMIN;
                    end else begin
                        FAIL    <= 1'b1;
                        ERR_CNT <= w_err_next;
                        if (w_err_next == MAX_CNT) begin
                            r_timer <= ALARM_LD;
                            ALARM   <= 1'b1;
                            r_state <= ST_ALARM;
                        end else begin
                            r_state <= ST_LOCKED;
                        end
                    end
                end

                ST_OPEN: begin
                    if (CLEAR || r_timer <= 16'd1) begin
                        UNLOCK  <= 1'b0;
                        r_timer <= 16'd0;
                        r_state <= ST_LOCKED;
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end

                ST_ADMIN: begin
                    if (CLEAR) begin
                        r_state <= ST_LOCKED;
                    end else if (CONFIRM) begin
                        if (w_entry_ok) begin
                            CODE_UPDATED <= 1'b1;
                            SEQ_CLEAR    <= 1'b1;
                            r_state      <= ST_LOCKED;
                        end else begin
                            INPUT_ERR <= 1'b1;
                        end
                    end
                end

                ST_ALARM: begin
                    if (r_timer <= 16'd1) begin
                        ALARM   <= 1'b0;
                        ERR_CNT <= 4'd0;
                        r_timer <= 16'd0;
                        r_state <= ST_LOCKED;
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end

                default: r_state <= ST_LOCKED;
            endcase
        end
    end

endmodule

// File: tb/tb_code_lock_ctrl.sv
`timescale 1ns/1ps
module tb_code_lock_ctrl;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic [15:0] SEQUENCE = 16'hFFFF;
    logic [2:0]  SEQUENCE_BIT = 3'd0;
    logic        CONFIRM = 1'b0;
    logic        CLEAR = 1'b0;
    logic        UNLOCK, ALARM, FAIL, INPUT_ERR, CODE_UPDATED, SEQ_CLEAR;
    logic [3:0]  ERR_CNT;
    logic [2:0]  STATE;

    int n_pass = 0;
    int n_total = 0;

    code_lock_ctrl dut (
        .CLK(CLK), .RESET_N(RESET_N), .SEQUENCE(SEQUENCE),
        .SEQUENCE_BIT(SEQUENCE_BIT), .CONFIRM(CONFIRM), .CLEAR(CLEAR),
        .UNLOCK(UNLOCK), .ALARM(ALARM), .FAIL(FAIL), .INPUT_ERR(INPUT_ERR),
        .CODE_UPDATED(CODE_UPDATED), .SEQ_CLEAR(SEQ_CLEAR),
        .ERR_CNT(ERR_CNT), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Present one CONFIRM cycle (optionally with CLEAR), then release inputs.
    task automatic enter(input logic [15:0] seq, input logic [2:0] bits, input logic clr);
        SEQUENCE = seq; SEQUENCE_BIT = bits; CONFIRM = 1'b1; CLEAR = clr;
        tick();
        CONFIRM = 1'b0; CLEAR = 1'b0; SEQUENCE = 16'hFFFF; SEQUENCE_BIT = 3'd0;
    endtask

    // Count cycles with UNLOCK high; pulse CLEAR during cycle clear_at (0 = never).
    task automatic open_run(input int clear_at, output int cnt);
        cnt = 0;
        while (UNLOCK === 1'b1 && cnt < 1000) begin
            cnt++;
            if (cnt == clear_at) CLEAR = 1'b1;
            tick();
            CLEAR = 1'b0;
        end
    endtask

    // Full entry ending in OPEN, then run the open window.
    task automatic unlock_with(input logic [15:0] seq, input int clear_at,
                               input int exp_cnt, input string tag);
        int cnt;
        enter(seq, 3'd4, 1'b0);
        chk({tag, "_check_state"}, STATE, 3'd1);
        tick();
        chk({tag, "_unlock"}, UNLOCK, 1'b1);
        chk({tag, "_open_state"}, STATE, 3'd2);
        open_run(clear_at, cnt);
        chk({tag, "_open_cycles"}, cnt, exp_cnt);
        chk({tag, "_relocked"}, STATE, 3'd0);
    endtask

    // Full entry ending in a FAIL pulse.
    task automatic fail_with(input logic [15:0] seq, input logic [3:0] exp_err,
                             input logic [2:0] exp_state, input string tag);
        enter(seq, 3'd4, 1'b0);
        tick();
        chk({tag, "_fail"}, FAIL, 1'b1);
        chk({tag, "_err_cnt"}, ERR_CNT, exp_err);
        chk({tag, "_state"}, STATE, exp_state);
    endtask

    initial begin
        int cnt;

        // Reset
        repeat (3) tick();
        chk("rst_state", STATE, 3'd0);
        chk("rst_unlock", UNLOCK, 1'b0);
        chk("rst_alarm", ALARM, 1'b0);
        chk("rst_err", ERR_CNT, 4'd0);
        chk("rst_pulses", {FAIL, INPUT_ERR, CODE_UPDATED, SEQ_CLEAR}, 4'b0000);
        RESET_N = 1'b1;
        tick();

        // Default code, typed 1-2-3-4 -> SEQUENCE 16'h4321
        enter(16'h4321, 3'd4, 1'b0);
        chk("ok_seq_clear", SEQ_CLEAR, 1'b1);
        chk("ok_check", STATE, 3'd1);
        chk("ok_no_unlock_yet", UNLOCK, 1'b0);
        tick();
        chk("ok_seq_clear_drop", SEQ_CLEAR, 1'b0);
        chk("ok_unlock", UNLOCK, 1'b1);
        chk("ok_open", STATE, 3'd2);
        open_run(0, cnt);
        chk("ok_open_cycles", cnt, 100);
        chk("ok_relock", STATE, 3'd0);

        // Short entry in LOCKED
        enter(16'hFF21, 3'd2, 1'b0);
        chk("short_input_err", INPUT_ERR, 1'b1);
        chk("short_no_seq_clear", SEQ_CLEAR, 1'b0);
        chk("short_state", STATE, 3'd0);
        chk("short_err_cnt", ERR_CNT, 4'd0);
        tick();
        chk("short_pulse_drop", INPUT_ERR, 1'b0);

        // Three failures -> alarm
        fail_with(16'h0000, 4'd1, 3'd0, "f1");
        tick();
        chk("f1_fail_drop", FAIL, 1'b0);
        fail_with(16'h0000, 4'd2, 3'd0, "f2");
        fail_with(16'h0000, 4'd3, 3'd4, "f3");
        chk("f3_alarm", ALARM, 1'b1);
        cnt = 0;
        while (ALARM === 1'b1 && cnt < 1000) begin
            cnt++;
            if (cnt == 5) begin SEQUENCE = 16'h4321; SEQUENCE_BIT = 3'd4; CONFIRM = 1'b1; end
            if (cnt == 6) begin SEQUENCE = 16'h9999; SEQUENCE_BIT = 3'd4; CONFIRM = 1'b1; CLEAR = 1'b1; end
            tick();
            CONFIRM = 1'b0; CLEAR = 1'b0;
            if (cnt == 5) chk("alarm_ignores_confirm", STATE, 3'd4);
        end
        chk("alarm_cycles", cnt, 200);
        chk("alarm_end_state", STATE, 3'd0);
        chk("alarm_end_err", ERR_CNT, 4'd0);
        chk("alarm_end_unlock", UNLOCK, 1'b0);

        // ADMIN: invalid BCD, then CLEAR leaves code unchanged
        enter(16'h9999, 3'd4, 1'b0);
        tick();
        chk("adm1_state", STATE, 3'd3);
        enter(16'h12A4, 3'd4, 1'b0);
        chk("adm1_bad_bcd_err", INPUT_ERR, 1'b1);
        chk("adm1_bad_bcd_state", STATE, 3'd3);
        chk("adm1_bad_bcd_no_fail", {FAIL, ERR_CNT}, 5'd0);
        enter(16'h5678, 3'd4, 1'b1);
        chk("adm1_clear_wins", STATE, 3'd0);
        chk("adm1_clear_no_update", CODE_UPDATED, 1'b0);
        unlock_with(16'h4321, 10, 10, "keep");

        // ADMIN: store 16'h5678
        enter(16'h9999, 3'd4, 1'b0);
        tick();
        chk("adm2_state", STATE, 3'd3);
        enter(16'h5678, 3'd4, 1'b0);
        chk("adm2_updated", CODE_UPDATED, 1'b1);
        chk("adm2_seq_clear", SEQ_CLEAR, 1'b1);
        chk("adm2_state_locked", STATE, 3'd0);
        tick();
        chk("adm2_updated_drop", CODE_UPDATED, 1'b0);
        fail_with(16'h4321, 4'd1, 3'd0, "old_code");
        unlock_with(16'h5678, 3, 3, "new_code");
        chk("new_code_err_clear", ERR_CNT, 4'd0);

        // CONFIRM and CLEAR together in LOCKED: CONFIRM is processed
        enter(16'h5678, 3'd4, 1'b1);
        chk("locked_confirm_wins", STATE, 3'd1);
        tick();
        chk("locked_confirm_opens", STATE, 3'd2);
        // Asynchronous reset in the middle of OPEN
        #3 RESET_N = 1'b0;
        #1;
        chk("async_rst_unlock", UNLOCK, 1'b0);
        chk("async_rst_state", STATE, 3'd0);
        tick();
        RESET_N = 1'b1;
        tick();

`ifdef CODE_LOCK_RETAIN_CODE_EN
        unlock_with(16'h5678, 0, 100, "retained");
        fail_with(16'h4321, 4'd1, 3'd0, "retained_old");
`else
        unlock_with(16'h4321, 0, 100, "restored");
        fail_with(16'h5678, 4'd1, 3'd0, "restored_old");
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
